// File: rtl/timer_pkg.sv
// Shared timer types and BCD helpers for the countdown, stopwatch and clock blocks.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_EXPIRED
    } state_e;

    localparam int BCD_W = 4;
    localparam int FLD_W = 8;

    localparam logic [FLD_W-1:0] SEC_MAX_BCD = 8'h59;
    localparam logic [FLD_W-1:0] MIN_MAX_BCD = 8'h99;

    // Returns {borrow_out, value}; a field at 00 with borrow_in wraps to wrap_val.
    function automatic logic [FLD_W:0] bcd_dec(
        input logic [FLD_W-1:0] v,
        input logic             bin,
        input logic [FLD_W-1:0] wrap_val
    );
        logic [FLD_W:0] r;
        if (!bin)
            r = {1'b0, v};
        else if (v == '0)
            r = {1'b1, wrap_val};
        else if (v[BCD_W-1:0] == '0)
            r = {1'b0, v[FLD_W-1:BCD_W] - 4'd1, 4'd9};
        else
            r = {1'b0, v[FLD_W-1:BCD_W], v[BCD_W-1:0] - 4'd1};
        return r;
    endfunction

    function automatic logic [FLD_W-1:0] bcd_clamp(
        input logic [FLD_W-1:0] v,
        input logic [FLD_W-1:0] max_val
    );
        logic [FLD_W-1:0] r;
        if (v[BCD_W-1:0] > 4'd9 || v[FLD_W-1:BCD_W] > 4'd9 || v > max_val)
            r = max_val;
        else
            r = v;
        return r;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: one-cycle pulse every DIV clocks, shared by timer blocks.
module tick_prescaler #(
    parameter int DIV = 50_000
) (
    input  logic i_clk,
    input  logic i_rstn,
    output logic o_pls_1k
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge i_clk) begin
        if (!i_rstn)
            cnt_q <= '0;
        else if (cnt_q == CNT_MAX)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + 1'b1;
    end

    assign o_pls_1k = (cnt_q == CNT_MAX);

endmodule

// File: rtl/countdown_alarm.sv
// MM:SS BCD countdown that fires a one-cycle go strobe to the buzzer on expiry.
// Build option COUNTDOWN_AUTO_RELOAD_EN reloads the time on expiry for a periodic alarm.
module countdown_alarm
    import timer_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int PLS_HZ        = 1000,
    parameter int TICKS_PER_SEC = 1000
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_load,
    input  logic [FLD_W-1:0] i_min_bcd,
    input  logic [FLD_W-1:0] i_sec_bcd,
    input  logic             i_start,
    input  logic             i_pause,
    input  logic             i_clear,
    output logic             o_pls_1k,
    output logic             o_go,
    output logic [FLD_W-1:0] o_min_bcd,
    output logic [FLD_W-1:0] o_sec_bcd,
    output logic             o_running,
    output logic             o_done
);

    localparam int DIV  = CLK_HZ / PLS_HZ;
    localparam int MS_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [MS_W-1:0] MS_MAX = MS_W'(TICKS_PER_SEC - 1);

    state_e state_q, state_d;

    logic [FLD_W-1:0] min_q, min_d;
    logic [FLD_W-1:0] sec_q, sec_d;
    logic [FLD_W-1:0] rmin_q, rmin_d;
    logic [FLD_W-1:0] rsec_q, rsec_d;
    logic [MS_W-1:0]  ms_q, ms_d;
    logic             go_q, go_d;

    logic             pls;
    logic             sec_tick;
    logic             zero_next;
    logic             time_nz;
    logic [FLD_W:0]   sec_dec;
    logic [FLD_W:0]   min_dec;

    tick_prescaler #(
        .DIV(DIV)
    ) u_presc (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .o_pls_1k(pls)
    );

    assign sec_tick = (state_q == ST_RUN) && pls && (ms_q == MS_MAX);
    assign sec_dec  = bcd_dec(sec_q, 1'b1, SEC_MAX_BCD);
    assign min_dec  = bcd_dec(min_q, sec_dec[FLD_W], MIN_MAX_BCD);
    assign time_nz  = (min_q != '0) || (sec_q != '0);

    // Minute underflow cannot occur from a nonzero time; treat it as expiry.
    assign zero_next = min_dec[FLD_W] ||
                       ((min_dec[FLD_W-1:0] == '0) && (sec_dec[FLD_W-1:0] == '0));

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            min_q   <= '0;
            sec_q   <= '0;
            rmin_q  <= '0;
            rsec_q  <= '0;
            ms_q    <= '0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            rmin_q  <= rmin_d;
            rsec_q  <= rsec_d;
            ms_q    <= ms_d;
            go_q    <= go_d;
        end
    end

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        rmin_d  = rmin_q;
        rsec_d  = rsec_q;
        ms_d    = ms_q;
        go_d    = 1'b0;

        if (state_q == ST_RUN && pls)
            ms_d = (ms_q == MS_MAX) ? '0 : ms_q + 1'b1;

        if (i_clear) begin
            state_d = ST_IDLE;
            min_d   = '0;
            sec_d   = '0;
            ms_d    = '0;
        end else if (i_load) begin
            state_d = ST_IDLE;
            min_d   = bcd_clamp(i_min_bcd, MIN_MAX_BCD);
            sec_d   = bcd_clamp(i_sec_bcd, SEC_MAX_BCD);
            rmin_d  = bcd_clamp(i_min_bcd, MIN_MAX_BCD);
            rsec_d  = bcd_clamp(i_sec_bcd, SEC_MAX_BCD);
            ms_d    = '0;
        end else if (sec_tick && zero_next) begin
            go_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            if ((rmin_q != '0) || (rsec_q != '0)) begin
                min_d = rmin_q;
                sec_d = rsec_q;
            end else begin
                state_d = ST_EXPIRED;
                min_d   = '0;
                sec_d   = '0;
            end
`else
            state_d = ST_EXPIRED;
            min_d   = '0;
            sec_d   = '0;
`endif
        end else begin
            if (sec_tick) begin
                sec_d = sec_dec[FLD_W-1:0];
                min_d = min_dec[FLD_W-1:0];
            end
            if (i_start) begin
                if (state_q == ST_IDLE && time_nz) begin
                    state_d = ST_RUN;
                    ms_d    = '0;
                end else if (state_q == ST_PAUSE) begin
                    state_d = ST_RUN;
                end
            end else if (i_pause && state_q == ST_RUN) begin
                state_d = ST_PAUSE;
            end
        end
    end

    assign o_pls_1k  = pls;
    assign o_go      = go_q;
    assign o_min_bcd = min_q;
    assign o_sec_bcd = sec_q;
    assign o_running = (state_q == ST_RUN);
    assign o_done    = (state_q == ST_EXPIRED);

endmodule

// File: tb/tb_countdown_alarm.sv
// Directed bench for countdown_alarm at DIV=4 (one second = 4000 clocks).
`timescale 1ns/1ps
module tb_countdown_alarm;

    logic       i_clk = 1'b0;
    logic       i_rstn = 1'b0;
    logic       i_load = 1'b0;
    logic       i_start = 1'b0;
    logic       i_pause = 1'b0;
    logic       i_clear = 1'b0;
    logic [7:0] i_min_bcd = 8'h00;
    logic [7:0] i_sec_bcd = 8'h00;
    logic       o_pls_1k, o_go, o_running, o_done;
    logic [7:0] o_min_bcd, o_sec_bcd;

    int n_cmp = 0;
    int n_err = 0;

    countdown_alarm #(
        .CLK_HZ(4000),
        .PLS_HZ(1000),
        .TICKS_PER_SEC(1000)
    ) dut (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_load   (i_load),
        .i_min_bcd(i_min_bcd),
        .i_sec_bcd(i_sec_bcd),
        .i_start  (i_start),
        .i_pause  (i_pause),
        .i_clear  (i_clear),
        .o_pls_1k (o_pls_1k),
        .o_go     (o_go),
        .o_min_bcd(o_min_bcd),
        .o_sec_bcd(o_sec_bcd),
        .o_running(o_running),
        .o_done   (o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic strobe(input logic ld, input logic st, input logic pa, input logic cl,
                          input logic [7:0] m, input logic [7:0] s);
        i_load = ld; i_start = st; i_pause = pa; i_clear = cl;
        i_min_bcd = m; i_sec_bcd = s;
        step(1);
        i_load = 0; i_start = 0; i_pause = 0; i_clear = 0;
    endtask

    function automatic logic in_rng(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

    initial begin
        int first01, gok, gos, run, k;
        logic [15:0] go_disp;

        // reset values and prescaler phase
        step(3);
        chk("rst_pls", o_pls_1k, 0);
        chk("rst_go", o_go, 0);
        chk("rst_time", {o_min_bcd, o_sec_bcd}, 16'h0000);
        chk("rst_run", o_running, 0);
        chk("rst_done", o_done, 0);
        i_rstn = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            chk($sformatf("pls_c%0d", c), o_pls_1k, (c % 4 == 0));
            chk($sformatf("go_c%0d", c), o_go, 0);
            step(1);
        end
        chk("idle_time", {o_min_bcd, o_sec_bcd}, 16'h0000);
        chk("idle_run", o_running, 0);

`ifndef COUNTDOWN_AUTO_RELOAD_EN
        // single-shot 00:02
        strobe(1, 0, 0, 0, 8'h00, 8'h02);
        chk("ld2_time", {o_min_bcd, o_sec_bcd}, 16'h0002);
        strobe(0, 1, 0, 0, 8'h00, 8'h00);
        chk("st2_run", o_running, 1);
        first01 = -1; gok = -1; gos = 0; go_disp = 16'hffff;
        for (int j = 1; j <= 8100; j++) begin
            step(1);
            if (first01 < 0 && o_sec_bcd == 8'h01) first01 = j;
            if (o_go) begin
                gos++;
                if (gok < 0) begin
                    gok = j;
                    go_disp = {o_min_bcd, o_sec_bcd};
                end
            end
        end
        chk("t01_in_4000", in_rng(first01, 3997, 4003), 1);
        chk("go_in_8000", in_rng(gok, 7997, 8003), 1);
        chk("go_count", gos, 1);
        chk("go_disp", go_disp, 16'h0000);
        chk("exp_done", o_done, 1);
        chk("exp_run", o_running, 0);
        strobe(0, 1, 0, 0, 8'h00, 8'h00);
        step(5);
        chk("exp_start_ign", o_done, 1);
        chk("exp_go_quiet", o_go, 0);
        strobe(0, 0, 0, 1, 8'h00, 8'h00);
        chk("clr_done", o_done, 0);
`endif

        // reset mid-count
        strobe(1, 0, 0, 0, 8'h00, 8'h01);
        strobe(0, 1, 0, 0, 8'h00, 8'h00);
        step(2000);
        i_rstn = 1'b0;
        step(1);
        chk("mrst_time", {o_min_bcd, o_sec_bcd}, 16'h0000);
        chk("mrst_run", o_running, 0);
        i_rstn = 1'b1;
        gos = 0;
        for (int j = 0; j < 3000; j++) begin
            step(1);
            if (o_go) gos++;
        end
        chk("mrst_no_go", gos, 0);

        // borrow 01:00 -> 00:59 and load clamping
        strobe(1, 0, 0, 0, 8'h01, 8'h00);
        strobe(0, 1, 0, 0, 8'h00, 8'h00);
        k = -1;
        for (int j = 1; j <= 4100 && k < 0; j++) begin
            step(1);
            if (o_sec_bcd != 8'h00) k = j;
        end
        chk("brw_time", {o_min_bcd, o_sec_bcd}, 16'h0059);
        chk("brw_at_4000", in_rng(k, 3997, 4003), 1);
        strobe(1, 0, 0, 0, 8'h01, 8'h7A);
        chk("clamp_7A", {o_min_bcd, o_sec_bcd}, 16'h0159);
        chk("clamp_run", o_running, 0);
        strobe(1, 0, 0, 0, 8'hA5, 8'h60);
        chk("clamp_A5_60", {o_min_bcd, o_sec_bcd}, 16'h9959);
        strobe(1, 0, 0, 0, 8'h99, 8'h59);
        chk("max_ok", {o_min_bcd, o_sec_bcd}, 16'h9959);

        // pause/resume from 00:03
        strobe(1, 0, 0, 0, 8'h00, 8'h03);
        strobe(0, 1, 0, 0, 8'h00, 8'h00);
        step(1500);
        strobe(0, 0, 1, 0, 8'h00, 8'h00);
        run = 1501;
        chk("pause_run", o_running, 0);
        gos = 0;
        for (int j = 0; j < 9999; j++) begin
            step(1);
            if (o_go) gos++;
        end
        chk("pause_no_go", gos, 0);
        chk("pause_hold", {o_min_bcd, o_sec_bcd}, 16'h0003);
        strobe(0, 1, 0, 0, 8'h00, 8'h00);
        chk("resume_run", o_running, 1);
        gok = -1;
        for (int j = 0; j < 11000 && gok < 0; j++) begin
            step(1);
            run++;
            if (o_go) gok = run;
        end
        chk("pause_go_12000", in_rng(gok, 11997, 12003), 1);

        // strobe corner cases
        strobe(0, 0, 0, 1, 8'h00, 8'h00);
        strobe(0, 1, 0, 0, 8'h00, 8'h00);
        chk("st0_run", o_running, 0);
        step(3);
        chk("st0_go", o_go, 0);
        strobe(1, 0, 0, 0, 8'h00, 8'h05);
        strobe(0, 1, 0, 1, 8'h00, 8'h00);
        chk("stclr_run", o_running, 0);
        chk("stclr_time", {o_min_bcd, o_sec_bcd}, 16'h0000);
        chk("stclr_go", o_go, 0);
        strobe(1, 1, 0, 0, 8'h00, 8'h07);
        chk("ldst_time", {o_min_bcd, o_sec_bcd}, 16'h0007);
        chk("ldst_run", o_running, 0);
        strobe(0, 1, 0, 0, 8'h00, 8'h00);
        chk("ldst_then_st", o_running, 1);
        strobe(1, 0, 0, 1, 8'h00, 8'h09);
        chk("clrld_time", {o_min_bcd, o_sec_bcd}, 16'h0000);
        chk("clrld_run", o_running, 0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        // periodic alarm 00:01
        begin
            int gt[3];
            int nrun;
            gos = 0; nrun = 0;
            strobe(1, 0, 0, 0, 8'h00, 8'h01);
            strobe(0, 1, 0, 0, 8'h00, 8'h00);
            for (int j = 1; j <= 12100; j++) begin
                step(1);
                if (!o_running) nrun++;
                if (o_go) begin
                    if (gos < 3) gt[gos] = j;
                    gos++;
                    chk($sformatf("rld_disp%0d", gos), {o_min_bcd, o_sec_bcd}, 16'h0001);
                end
            end
            chk("rld_count", gos, 3);
            chk("rld_go1", in_rng(gt[0], 3997, 4003), 1);
            chk("rld_go2", in_rng(gt[1], 7997, 8003), 1);
            chk("rld_go3", in_rng(gt[2], 11997, 12003), 1);
            chk("rld_running", nrun, 0);
            chk("rld_done", o_done, 0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
